// File: rtl/pipeline_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit_pkg
// Shared types and constants for the pipeline control unit: sequencer state,
// pause vector bit positions, the MEM-stage control bundle and the packed
// ctrl / ctrl_pc output layouts.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pipeline_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    IDLE  = 2'd2
  } ctrl_state_t;

  // Bit positions inside ctrl_t.pause, front of the pipe first.
  localparam int PAUSE_PC       = 0;
  localparam int PAUSE_IF       = 1;
  localparam int PAUSE_ID       = 2;
  localparam int PAUSE_DISPATCH = 3;
  localparam int PAUSE_EX       = 4;
  localparam int PAUSE_MEM      = 5;
  localparam int PAUSE_WB       = 6;

  localparam int NUM_EXCP_STAGES = 6;

  typedef logic [7:0] alu_op_t;
  typedef logic [6:0] exception_cause_t;

  // ALU op encoding used to recognise the IDLE instruction, and the cause
  // code reported when an interrupt is taken.
  localparam alu_op_t          ALU_IDLE  = 8'h5A;
  localparam exception_cause_t ECODE_INT = 7'h00;

  // While waiting in IDLE everything up to and including MEM is frozen;
  // WB is never held so in-flight writebacks drain.
  localparam logic [6:0] IDLE_PAUSE = 7'b0111111;

  typedef struct packed {
    logic [31:0]                                pc;
    alu_op_t                                    aluop;
    logic                                       is_ertn;
    logic                                       pause_mem;
    logic [NUM_EXCP_STAGES-1:0]                 is_exception;
    exception_cause_t [NUM_EXCP_STAGES-1:0]     exception_cause;
    logic [31:0]                                exception_addr;
  } mem_ctrl_t;

  typedef struct packed {
    logic [6:0] pause;
    logic       exception_flush;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] exception_new_pc;
    logic        is_interrupt;
  } ctrl_pc_t;

  // Mask with bits 0..stage set: a stall at one stage must also hold every
  // stage in front of it.
  function automatic logic [6:0] pause_upto(input int stage);
    logic [6:0] mask;
    mask = '0;
    for (int i = 0; i < 7; i++) begin
      if (i <= stage) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_excp_prio_enc.sv
// ---------------------------------------------------------------------------
// excp_prio_enc
// Six-way priority encoder over the per-stage exception flags carried into
// MEM. The highest set index belongs to the earliest pipeline stage and wins,
// since that exception happened first in program order for this instruction.
// Ports:
//   is_exception     in  6   per-stage exception flags
//   exception_cause  in  42  six packed 7-bit causes, entry i at [7*i +: 7]
//   valid            out 1   any exception flag set
//   cause            out 7   cause of the winning stage
// ---------------------------------------------------------------------------
module excp_prio_enc
  import pipeline_ctrl_unit_pkg::*;
(
  input  logic [5:0]  is_exception,
  input  logic [41:0] exception_cause,
  output logic        valid,
  output logic [6:0]  cause
);

  // Scan upward so a higher set index overwrites any lower one.
  always_comb begin
    valid = 1'b0;
    cause = '0;
    for (int i = 0; i < NUM_EXCP_STAGES; i++) begin
      if (is_exception[i]) begin
        valid = 1'b1;
        cause = exception_cause[7*i +: 7];
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit
// Central pipeline sequencer: merges stall requests into the pause vector,
// commits interrupts / exceptions / ertn at the MEM stage, drives the PC
// redirect and sequences RUN -> FLUSH -> RUN and RUN -> IDLE -> FLUSH.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pause_if_req       fetch stall (holds pc, if)
//   pause_req[3:0]     {id, dispatch, ex, mem} stall requests
//   mem_valid          MEM holds a real instruction
//   mem_ctrl           MEM-stage control bundle
//   csr_eentry         exception entry address
//   csr_era            ertn return address
//   csr_int_pending    enabled, unmasked interrupt pending
//   ctrl[7:0]          {pause[6:0], exception_flush}
//   ctrl_pc[32:0]      {exception_new_pc, is_interrupt}
//   redirect_valid     1-cycle pulse, PC loads exception_new_pc
//   excp_commit        1-cycle pulse to CSR for interrupt/exception entry
//   excp_cause/epc/badv  committed cause, ERA and bad address (held)
//   ertn_commit        1-cycle pulse to CSR for ertn
// ---------------------------------------------------------------------------
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [7:0] IDLE_ALUOP   = ALU_IDLE,
  parameter logic [6:0] INT_CAUSE    = ECODE_INT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_if_req,
  input  logic [3:0]  pause_req,
  input  logic        mem_valid,
  input  mem_ctrl_t   mem_ctrl,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        csr_int_pending,
  output logic [7:0]  ctrl,
  output logic [32:0] ctrl_pc,
  output logic        redirect_valid,
  output logic        excp_commit,
  output logic [6:0]  excp_cause,
  output logic [31:0] excp_epc,
  output logic [31:0] excp_badv,
  output logic        ertn_commit
);

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t      state;
  ctrl_state_t      next_state;
  logic [CNT_W-1:0] flush_cnt;
  logic [31:0]      idle_epc;

  logic             enc_valid;
  logic [6:0]       enc_cause;

  logic             commit_point;
  logic             take_int;
  logic             take_exc;
  logic             take_ertn;
  logic             take_idle;
  logic             take_redirect;

  logic [6:0]       run_pause;
  ctrl_t            ctrl_s;
  ctrl_pc_t         ctrl_pc_q;

  excp_prio_enc u_excp_prio_enc (
    .is_exception    (mem_ctrl.is_exception),
    .exception_cause (mem_ctrl.exception_cause),
    .valid           (enc_valid),
    .cause           (enc_cause)
  );

  // Commit decisions. Only one of the take_* signals can be high in a cycle;
  // an interrupt wakes IDLE even though MEM holds nothing committable there.
  always_comb begin
    commit_point  = (state == RUN) && mem_valid && !mem_ctrl.pause_mem;
    take_int      = csr_int_pending && (commit_point || (state == IDLE));
    take_exc      = commit_point && !csr_int_pending && enc_valid;
    take_ertn     = commit_point && !csr_int_pending && !enc_valid &&
                    mem_ctrl.is_ertn;
    take_idle     = commit_point && !csr_int_pending && !enc_valid &&
                    !mem_ctrl.is_ertn && (mem_ctrl.aluop == IDLE_ALUOP);
    take_redirect = take_int || take_exc || take_ertn;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. FLUSH ignores every commit source until the counter
  // runs out, so nothing can commit in the final flush cycle.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (take_redirect) begin
          next_state = FLUSH;
        end else if (take_idle) begin
          next_state = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          next_state = RUN;
        end
      end
      IDLE: begin
        if (take_int) begin
          next_state = FLUSH;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // Stall merge while running: each request holds its own stage and all
  // stages ahead of it. MEM can stall either via pause_req or the bundle.
  always_comb begin
    run_pause = '0;
    if (pause_if_req) begin
      run_pause = run_pause | pause_upto(PAUSE_IF);
    end
    if (pause_req[3]) begin
      run_pause = run_pause | pause_upto(PAUSE_ID);
    end
    if (pause_req[2]) begin
      run_pause = run_pause | pause_upto(PAUSE_DISPATCH);
    end
    if (pause_req[1]) begin
      run_pause = run_pause | pause_upto(PAUSE_EX);
    end
    if (pause_req[0] || mem_ctrl.pause_mem) begin
      run_pause = run_pause | pause_upto(PAUSE_MEM);
    end
  end

  // Output logic for the pause/flush vector, decoded from the current state.
  always_comb begin
    ctrl_s = '0;
    case (state)
      RUN:     ctrl_s.pause = run_pause;
      FLUSH:   ctrl_s.exception_flush = 1'b1;
      IDLE:    ctrl_s.pause = IDLE_PAUSE;
      default: ctrl_s = '0;
    endcase
  end

  assign ctrl    = ctrl_s;
  assign ctrl_pc = ctrl_pc_q;

  // Flush window counter, loaded so that FLUSH lasts FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (take_redirect) begin
      flush_cnt <= CNT_LOAD;
    end else if ((state == FLUSH) && (flush_cnt != '0)) begin
      flush_cnt <= flush_cnt - CNT_W'(1);
    end
  end

  // The interrupt that wakes IDLE must return past the IDLE instruction,
  // so its successor's address is captured on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_epc <= '0;
    end else if (take_idle) begin
      idle_epc <= mem_ctrl.pc + 32'd4;
    end
  end

  // Commit registers. Pulses last exactly the first FLUSH cycle; the redirect
  // target stays visible for the whole window and is cleared once FLUSH ends.
  // Cause/epc/badv keep their last committed value between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      excp_commit    <= 1'b0;
      ertn_commit    <= 1'b0;
      excp_cause     <= '0;
      excp_epc       <= '0;
      excp_badv      <= '0;
      ctrl_pc_q      <= '0;
    end else begin
      redirect_valid <= take_redirect;
      excp_commit    <= take_int || take_exc;
      ertn_commit    <= take_ertn;
      if (take_int) begin
        excp_cause                 <= INT_CAUSE;
        excp_epc                   <= (state == IDLE) ? idle_epc : mem_ctrl.pc;
        ctrl_pc_q.exception_new_pc <= csr_eentry;
        ctrl_pc_q.is_interrupt     <= 1'b1;
      end else if (take_exc) begin
        excp_cause                 <= enc_cause;
        excp_epc                   <= mem_ctrl.pc;
        excp_badv                  <= mem_ctrl.exception_addr;
        ctrl_pc_q.exception_new_pc <= csr_eentry;
        ctrl_pc_q.is_interrupt     <= 1'b0;
      end else if (take_ertn) begin
        ctrl_pc_q.exception_new_pc <= csr_era;
        ctrl_pc_q.is_interrupt     <= 1'b0;
      end else if (next_state != FLUSH) begin
        ctrl_pc_q <= '0;
      end
    end
  end

endmodule
